adder_eval_ctrl: RTL and testbench

Sequencer that characterises the error of an 8-input/5-output approximate adder by sweeping its full input space. It drives the adder's `pi` bus with every input vector in turn, samples `po` after a programmable settle time, compares it with the exact sum, and accumulates three error metrics: mismatch count, maximum absolute error and sum of absolute errors. It sits between a host/test harness and one combinational approximate-adder instance in the error-evaluation flow.

---
 rtl/adder_eval_ctrl.sv | 115 +++++++++++
 tb/tb_adder_eval_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_eval_ctrl.sv
// Error-characterisation sequencer for an 8-in/5-out approximate adder:
// sweeps every input vector, compares po with the exact sum and accumulates metrics.
module adder_eval_ctrl #(
  parameter int IN_W   = 8,
  parameter int OUT_W  = 5,
  parameter int SETTLE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  output logic [IN_W-1:0]         pi,
  input  logic [OUT_W-1:0]        po,
  output logic                    busy,
  output logic                    done,
  output logic                    res_valid,
  output logic [IN_W:0]           err_count,
  output logic [OUT_W-1:0]        max_err,
  output logic [IN_W+OUT_W-1:0]   sum_err
);

  localparam int HALF = IN_W / 2;
  localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           state;
  logic [3:0]       cnt;
  logic [IN_W-1:0]  vec;
  logic [OUT_W-1:0] po_q;
  logic [OUT_W-1:0] op_a;
  logic [OUT_W-1:0] op_b;
  logic [OUT_W-1:0] exact;
  logic [OUT_W-1:0] e;

  assign pi = vec;

  // Operands are zero-extended so the exact sum never overflows OUT_W bits.
  always_comb begin
    op_a  = {{(OUT_W-HALF){1'b0}}, vec[HALF-1:0]};
    op_b  = {{(OUT_W-HALF){1'b0}}, vec[IN_W-1:HALF]};
    exact = op_a + op_b;
    e     = (po_q >= exact) ? (po_q - exact) : (exact - po_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      vec       <= '0;
      po_q      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      res_valid <= 1'b0;
      err_count <= '0;
      max_err   <= '0;
      sum_err   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            vec       <= '0;
            err_count <= '0;
            max_err   <= '0;
            sum_err   <= '0;
            res_valid <= 1'b0;
            cnt       <= SETTLE_LD;
            busy      <= 1'b1;
            state     <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (cnt == 4'd0) begin
            po_q  <= po;
            state <= S_SAMPLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_SAMPLE: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            if (e != '0) err_count <= err_count + {{IN_W{1'b0}}, 1'b1};
            if (e > max_err) max_err <= e;
            sum_err <= sum_err + {{IN_W{1'b0}}, e};
            if (&vec) begin
              busy      <= 1'b0;
              done      <= 1'b1;
              res_valid <= 1'b1;
              state     <= S_DONE;
            end else begin
              vec   <= vec + {{(IN_W-1){1'b0}}, 1'b1};
              cnt   <= SETTLE_LD;
              state <= S_SETTLE;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_eval_ctrl.sv
// Scoreboard bench for adder_eval_ctrl: two instances (SETTLE=1 and SETTLE=3)
// driving behavioural adder models; a monitor checks each done against queued results.
module tb_adder_eval_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int passed = 0;

  typedef struct {
    int ec;
    int me;
    int se;
    int dcyc;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];

  // Instance 1: SETTLE=1, selectable model (0 exact, 1 stuck-zero)
  logic        start1 = 1'b0, abort1 = 1'b0;
  logic [7:0]  pi1;
  logic [4:0]  po1;
  logic        busy1, done1, rv1;
  logic [8:0]  ec1;
  logic [4:0]  me1;
  logic [12:0] se1;
  int          mode1 = 0;

  // Instance 3: SETTLE=3, LSB-truncated model
  logic        start3 = 1'b0, abort3 = 1'b0;
  logic [7:0]  pi3;
  logic [4:0]  po3;
  logic        busy3, done3, rv3;
  logic [8:0]  ec3;
  logic [4:0]  me3;
  logic [12:0] se3;

  always_comb begin
    po1 = '0;
    if (mode1 == 0) po1 = {1'b0, pi1[3:0]} + {1'b0, pi1[7:4]};
    po3 = ({1'b0, pi3[3:0]} + {1'b0, pi3[7:4]}) & 5'b11110;
  end

  adder_eval_ctrl #(.IN_W(8), .OUT_W(5), .SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1),
    .pi(pi1), .po(po1), .busy(busy1), .done(done1), .res_valid(rv1),
    .err_count(ec1), .max_err(me1), .sum_err(se1)
  );

  adder_eval_ctrl #(.IN_W(8), .OUT_W(5), .SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .abort(abort3),
    .pi(pi3), .po(po3), .busy(busy3), .done(done3), .res_valid(rv3),
    .err_count(ec3), .max_err(me3), .sum_err(se3)
  );

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  // Monitors: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done1) begin
      if (q1.size() == 0) begin
        chk("dut1_unexpected_done", 1, 0);
      end else begin
        exp_t x;
        x = q1.pop_front();
        chk("dut1_err_count", 32'(ec1), x.ec);
        chk("dut1_max_err", 32'(me1), x.me);
        chk("dut1_sum_err", 32'(se1), x.se);
        chk("dut1_done_cycle", cyc, x.dcyc);
        chk("dut1_busy_at_done", 32'(busy1), 0);
        chk("dut1_res_valid_at_done", 32'(rv1), 1);
      end
    end
  end

  always @(negedge clk) begin
    if (done3) begin
      if (q3.size() == 0) begin
        chk("dut3_unexpected_done", 1, 0);
      end else begin
        exp_t x;
        x = q3.pop_front();
        chk("dut3_err_count", 32'(ec3), x.ec);
        chk("dut3_max_err", 32'(me3), x.me);
        chk("dut3_sum_err", 32'(se3), x.se);
        chk("dut3_done_cycle", cyc, x.dcyc);
        chk("dut3_res_valid_at_done", 32'(rv3), 1);
      end
    end
  end

  task automatic start_dut1(output int t0);
    @(negedge clk);
    start1 = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start1 = 1'b0;
    chk("dut1_busy_after_start", 32'(busy1), 1);
    chk("dut1_pi_after_start", 32'(pi1), 0);
  endtask

  task automatic wait_pi1(input int target);
    int n = 0;
    while (32'(pi1) != target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("dut1_wait_pi_timeout", 32'(pi1), target);
  endtask

  task automatic wait_idle1();
    int n = 0;
    while (busy1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("dut1_wait_idle_timeout", 32'(busy1), 0);
    @(negedge clk);
    chk("dut1_done_one_cycle", 32'(done1), 0);
    chk("dut1_res_valid_held", 32'(rv1), 1);
  endtask

  task automatic exact_run(input logic extra_start);
    int t0;
    exp_t x;
    mode1 = 0;
    start_dut1(t0);
    x.ec = 0; x.me = 0; x.se = 0; x.dcyc = t0 + 256 * 2 + 1;
    q1.push_back(x);
    if (extra_start) begin
      wait_pi1(8'h10);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
    end
    wait_idle1();
  endtask

  initial begin
    int t0;
    exp_t x;
    int ok;

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_pi", 32'(pi1), 0);
    chk("rst_busy", 32'(busy1), 0);
    chk("rst_done", 32'(done1), 0);
    chk("rst_res_valid", 32'(rv1), 0);
    chk("rst_err_count", 32'(ec1), 0);
    chk("rst_max_err", 32'(me1), 0);
    chk("rst_sum_err", 32'(se1), 0);
    chk("rst_busy3", 32'(busy3), 0);

    // Abort in IDLE has no effect
    abort1 = 1'b1;
    @(negedge clk);
    abort1 = 1'b0;
    chk("idle_abort_busy", 32'(busy1), 0);

    // Exact model
    exact_run(1'b0);

    // Stuck-zero model
    mode1 = 1;
    start_dut1(t0);
    x.ec = 255; x.me = 30; x.se = 3840; x.dcyc = t0 + 513;
    q1.push_back(x);
    wait_idle1();

    // Abort at vector 0x40 with stuck-zero model: partial metrics of 0x00..0x3F
    mode1 = 1;
    start_dut1(t0);
    wait_pi1(8'h40);
    abort1 = 1'b1;
    @(negedge clk);
    abort1 = 1'b0;
    chk("abort_busy", 32'(busy1), 0);
    chk("abort_res_valid", 32'(rv1), 0);
    chk("abort_partial_err_count", 32'(ec1), 63);
    chk("abort_partial_max_err", 32'(me1), 18);
    chk("abort_partial_sum_err", 32'(se1), 576);
    repeat (20) @(negedge clk);
    chk("abort_still_idle", 32'(busy1), 0);
    chk("abort_res_valid_later", 32'(rv1), 0);

    // Rerun after abort, then start-while-busy
    exact_run(1'b0);
    exact_run(1'b1);

    // Simultaneous start and abort in IDLE: start wins
    mode1 = 0;
    @(negedge clk);
    start1 = 1'b1;
    abort1 = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start1 = 1'b0;
    abort1 = 1'b0;
    chk("start_abort_busy", 32'(busy1), 1);
    chk("start_abort_res_valid", 32'(rv1), 0);
    x.ec = 0; x.me = 0; x.se = 0; x.dcyc = t0 + 513;
    q1.push_back(x);
    wait_idle1();

    // LSB-truncated model, SETTLE=3: pi steps every 4 cycles
    @(negedge clk);
    start3 = 1'b1;
    t0 = cyc;
    x.ec = 128; x.me = 1; x.se = 128; x.dcyc = t0 + 256 * 4 + 1;
    q3.push_back(x);
    for (int v = 0; v < 256; v++) begin
      ok = 1;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (v == 0 && k == 0) start3 = 1'b0;
        if (32'(pi3) != v || !busy3) ok = 0;
      end
      if (ok == 0) chk("dut3_pi_sequence", 32'(pi3), v);
      else chk("dut3_pi_sequence", v, v);
    end
    repeat (4) @(negedge clk);
    chk("dut3_idle_after", 32'(busy3), 0);
    chk("dut3_pi_holds_last", 32'(pi3), 255);

    // rst at vector 0x80
    mode1 = 1;
    start_dut1(t0);
    wait_pi1(8'h80);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_pi", 32'(pi1), 0);
    chk("midrst_busy", 32'(busy1), 0);
    chk("midrst_done", 32'(done1), 0);
    chk("midrst_res_valid", 32'(rv1), 0);
    chk("midrst_err_count", 32'(ec1), 0);
    chk("midrst_max_err", 32'(me1), 0);
    chk("midrst_sum_err", 32'(se1), 0);
    repeat (10) @(negedge clk);
    chk("midrst_stays_idle", 32'(busy1), 0);
    chk("midrst_pi_stays", 32'(pi1), 0);

    chk("dut1_pending_results", q1.size(), 0);
    chk("dut3_pending_results", q3.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
    $display("%0d/%0d checks passed", passed, total + 1);
    $fatal(1);
  end

endmodule
